// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial pattern detector: default sizes,
// controller state encoding and the pattern-length legality check.
package seq_ctrl_pkg;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // A length is usable only if it selects at least one bit and fits the history.
    function automatic logic len_legal(input logic [3:0] len, input int max_len);
        return (len != 4'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_matcher.sv
// History shift register, saturating fill counter and pattern comparator.
// hit reflects the history as it will look after the current shift.
module pattern_matcher
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = seq_ctrl_pkg::MAX_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
    input  logic               overlap,
    output logic               hit
);

    localparam int FILL_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] history_next;
    logic [MAX_LEN-1:0] mask;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_next;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        history_next = (history << 1) | MAX_LEN'(din);
        fill_next    = (fill == FILL_W'(MAX_LEN)) ? fill : fill + 1'b1;
        mask         = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift
            && (int'(fill_next) >= int'(len))
            && ((history_next & mask) == (pattern & mask));
    end

    // NOTE: the history is a plain register, not a memory, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= history_next;
            // Non-overlapping mode forces a full fresh pattern before the next hit.
            fill    <= (hit && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: configuration latch,
// IDLE/RUN/DONE/ERR sequencing, match pulse and saturating match counter.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = seq_ctrl_pkg::MAX_LEN,
    parameter int CNT_W   = seq_ctrl_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               din,
    input  logic               din_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state;
    state_t             state_next;
    logic               match_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   cnt_inc;

    logic [MAX_LEN-1:0] pattern;
    logic [3:0]         len;
    logic               overlap;
    logic [CNT_W-1:0]   target;

    logic               cfg_load;
    logic               start_ok;
    logic               run_start;
    logic               shift;
    logic               hit;

    // Configuration is frozen while a run is in progress.
    assign cfg_load  = cfg_we && (state != ST_RUN);
    // DONE with cfg_we goes back to IDLE, so a start there is not honoured.
    assign start_ok  = start && !abort
                    && ((state == ST_IDLE) || ((state == ST_DONE) && !cfg_we));
    assign run_start = start_ok && len_legal(len, MAX_LEN);
    assign shift     = (state == ST_RUN) && din_valid && !abort;
    assign cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;

    pattern_matcher #(
        .MAX_LEN (MAX_LEN)
    ) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clear   (run_start),
        .shift   (shift),
        .din     (din),
        .pattern (pattern),
        .len     (len),
        .overlap (overlap),
        .hit     (hit)
    );

    always_comb begin
        state_next = state;
        match_next = 1'b0;
        cnt_next   = match_cnt;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if ((state == ST_DONE) && cfg_we) begin
                    state_next = ST_IDLE;
                end else if (start_ok) begin
                    if (run_start) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (hit) begin
                    match_next = 1'b1;
                    cnt_next   = cnt_inc;
                    if ((target != '0) && (cnt_inc == target)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_ERR: begin
                if (cfg_we) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_next;
            match     <= match_next;
            match_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
            len     <= 4'd1;
            overlap <= 1'b1;
            target  <= '0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= cfg_len;
            overlap <= cfg_overlap;
            target  <= cfg_target;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus random
// traffic, all compared against a bit-queue reference model.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               din;
    logic               din_valid;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Reference model: received bits kept as a queue, matched by direct comparison.
    bit         m_run, m_done, m_err, m_match;
    int         m_cnt;
    bit [7:0]   m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_tgt;
    bit         q_bits[$];

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_err = 0; m_match = 0; m_cnt = 0;
        m_pat = 8'd0; m_len = 1; m_ovl = 1; m_tgt = 0;
        q_bits.delete();
    endfunction

    function automatic void model_latch();
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        m_tgt = int'(cfg_target);
    endfunction

    function automatic bit tail_matches();
        int n;
        n = q_bits.size();
        if (n < m_len) return 0;
        for (int i = 0; i < m_len; i++) begin
            if (q_bits[n-1-i] != m_pat[i]) return 0;
        end
        return 1;
    endfunction

    function automatic void model_step();
        int old_len;
        m_match = 0;
        if (m_run) begin
            if (abort) begin
                m_run = 0;
            end else if (din_valid) begin
                q_bits.push_back(din);
                if (q_bits.size() > MAX_LEN) void'(q_bits.pop_front());
                if (tail_matches()) begin
                    m_match = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (!m_ovl) q_bits.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end
        end else if (m_err) begin
            if (cfg_we) begin
                model_latch();
                m_err = 0;
            end
        end else if (m_done && cfg_we) begin
            model_latch();
            m_done = 0;
        end else begin
            old_len = m_len;
            if (cfg_we) model_latch();
            if (start && !abort) begin
                m_done = 0;
                if (old_len >= 1 && old_len <= MAX_LEN) begin
                    m_run = 1;
                    m_cnt = 0;
                    q_bits.delete();
                end else begin
                    m_err = 1;
                end
            end
        end
    endfunction

    function automatic logic [CNT_W+3:0] obs();
        return {match, busy, done, err, match_cnt};
    endfunction

    function automatic logic [CNT_W+3:0] expv();
        return {m_match, m_run, m_done, m_err, CNT_W'(m_cnt)};
    endfunction

    task automatic idle_inputs();
        cfg_we = 0; start = 0; abort = 0; din = 0; din_valid = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl, input int tgt);
        cfg_we      = 1;
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ovl;
        cfg_target  = CNT_W'(tgt);
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        cfg_pattern = '0; cfg_len = 4'd1; cfg_overlap = 1; cfg_target = '0;
        rst = 1;
        model_reset();
        #2;
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", obs());
        end
        @(negedge clk);
        rst = 0;
        tick();
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic run_stream(input string name, input bit ovl);
        bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
        do_cfg(8'b1011, 4, ovl, 0);
        start = 1;
        tick();
        checks++;
        if (obs() !== expv() || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_start got=%h exp=%h", name, obs(), expv());
        end
        for (int i = 0; i < 7; i++) begin
            din = s[i]; din_valid = 1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL %s_bit%0d got=%h exp=%h", name, i + 1, obs(), expv());
            end
            checks++;
            if (match !== ((i == 3) || (ovl && i == 6))) begin
                failures++;
                $display("FAIL %s_pulse%0d got=%b", name, i + 1, match);
            end
        end
        checks++;
        if (match_cnt !== (ovl ? 8'd2 : 8'd1)) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, match_cnt, ovl ? 2 : 1);
        end
        abort = 1;
        tick();
        checks++;
        if (obs() !== expv() || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_abort got=%h exp=%h", name, obs(), expv());
        end
    endtask

    task automatic test_overlap();
        run_stream("overlap", 1'b1);
    endtask

    task automatic test_nonoverlap();
        run_stream("nonoverlap", 1'b0);
    endtask

    task automatic test_target();
        do_cfg(8'b1, 1, 1, 3);
        start = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            din = 1; din_valid = 1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL target_bit%0d got=%h exp=%h", i + 1, obs(), expv());
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd3 || match !== 1'b0) begin
            failures++;
            $display("FAIL target_final got done=%b busy=%b cnt=%0d match=%b exp 1 0 3 0",
                     done, busy, match_cnt, match);
        end
    endtask

    task automatic test_cfg_error();
        do_cfg(8'b11, 0, 1, 0);
        start = 1;
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL cfgerr_enter got=%h exp=%h", obs(), expv());
        end
        start = 1;
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cfgerr_start_ignored got err=%b busy=%b exp 1 0", err, busy);
        end
        do_cfg(8'b11, 2, 1, 0);
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL cfgerr_clear got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_abort_collision();
        bit s[3] = '{1, 0, 1};
        do_cfg(8'b1011, 4, 1, 0);
        start = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            din = s[i]; din_valid = 1;
            tick();
        end
        din = 1; din_valid = 1; abort = 1;
        tick();
        checks++;
        if (match !== 1'b0 || match_cnt !== 8'd0 || busy !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL abort_collision got=%h exp=%h", obs(), expv());
        end
        start = 1; abort = 1;
        tick();
        checks++;
        if (busy !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL abort_over_start got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_reset_midrun();
        bit s[3] = '{0, 1, 1};
        do_cfg(8'b1011, 4, 1, 0);
        start = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            din = s[i] ^ (i == 0); din_valid = 1;
            tick();
        end
        #3 rst = 1;
        model_reset();
        #1;
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL midrun_reset_async got=%h exp=0", obs());
        end
        @(posedge clk);
        #1 rst = 0;
        do_cfg(8'b1011, 4, 1, 0);
        start = 1;
        tick();
        din = 1; din_valid = 1;
        tick();
        checks++;
        if (match !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL midrun_no_stale_match got=%h exp=%h", obs(), expv());
        end
        for (int i = 0; i < 3; i++) begin
            din = s[i]; din_valid = 1;
            tick();
        end
        checks++;
        if (match !== 1'b1 || match_cnt !== 8'd1 || obs() !== expv()) begin
            failures++;
            $display("FAIL midrun_full_pattern got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            cfg_we      = ($urandom_range(0, 29) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 4));
            start       = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            din         = 1'($urandom);
            din_valid   = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h exp=%h", n, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_target();
        test_cfg_error();
        test_abort_collision();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
